sd_card_cmd_responder: RTL and testbench

Card-side endpoint of the SD CMD line: deserialises 48-bit host command frames from `CMD_PIN_IN`, checks framing and CRC7, hands index/argument to card logic, then serialises the 48-bit short (R1/R3/R6/R7) or 136-bit long (R2) response back on `CMD_PIN_OUT`. It sits in the SD card model / card-side bench environment and mirrors the host `CMD` block bit for bit, running entirely on the SD clock.

---
 rtl/sd_cmd_pkg.sv | 34 +++
 rtl/sd_crc7.sv | 21 ++
 rtl/sd_card_cmd_responder.sv | 195 +++++++++++++++++++
 tb/tb_sd_card_cmd_responder.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_cmd_pkg.sv
// Shared definitions for the SD CMD line: FSM states, response codes, frame
// lengths and the CRC7 generator, common to card-side and host-side models.
package sd_cmd_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RX,
        S_WAIT_RESP,
        S_TX
    } cmd_state_t;

    localparam logic [1:0] RESP_NONE  = 2'd0;
    localparam logic [1:0] RESP_SHORT = 2'd1;
    localparam logic [1:0] RESP_LONG  = 2'd2;

    localparam logic [5:0] CMD_LAST_BIT = 6'd47;
    localparam logic [5:0] CMD_CRC_SPAN = 6'd40;

    localparam logic [7:0] SHORT_FRAME_LEN = 8'd48;
    localparam logic [7:0] LONG_FRAME_LEN  = 8'd136;
    localparam logic [7:0] SHORT_CRC_END   = 8'd40;
    localparam logic [7:0] LONG_CRC_END    = 8'd128;
    localparam logic [7:0] LONG_HDR_LEN    = 8'd8;

    // x^7 + x^3 + 1 with the x^7 term implied
    localparam logic [6:0] CRC7_POLY = 7'h09;

    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic data_bit);
        logic fb;
        fb = data_bit ^ crc[6];
        return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    endfunction

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 accumulator, one bit per enabled clock, MSB of the frame first.
module sd_crc7
    import sd_cmd_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       enable,
    input  logic       data_bit,
    output logic [6:0] crc
);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            crc <= 7'h00;
        end else if (enable) begin
            crc <= crc7_step(crc, data_bit);
        end
    end

endmodule

// File: rtl/sd_card_cmd_responder.sv
// Card-side SD CMD endpoint: receives 48-bit host commands, checks CRC7, and
// serialises the short (48-bit) or long (136-bit) response back onto the pad.
module sd_card_cmd_responder
    import sd_cmd_pkg::*;
#(
    parameter int NCR_MIN = 2,
    parameter int NCR_MAX = 64
) (
    input  logic         clk_SD,
    input  logic         reset_SD,
    input  logic         CMD_PIN_IN,
    output logic         CMD_PIN_OUT,
    output logic         io_enable_cmd,
    output logic         cmd_valid,
    output logic [5:0]   cmd_index,
    output logic [31:0]  cmd_argument,
    output logic         crc_error,
    input  logic         resp_valid,
    input  logic [1:0]   resp_type,
    input  logic [31:0]  resp_status,
    input  logic [127:0] resp_long,
    output logic         resp_timeout,
    output logic         busy
);

    cmd_state_t     state;
    logic [5:0]     rx_cnt;
    logic [44:0]    rx_shift;
    logic           rx_dir;
    logic [7:0]     ncr_cnt;
    logic           have_resp;
    logic           tx_long;
    logic [135:0]   tx_shift;
    logic [7:0]     tx_cnt;

    logic [6:0]     crc_rx;
    logic [6:0]     crc_tx;
    logic           rx_crc_en;
    logic           rx_crc_clr;
    logic           tx_crc_en;
    logic           tx_crc_clr;
    logic [7:0]     tx_data_len;
    logic [7:0]     tx_len;
    logic [2:0]     tx_crc_sel;
    logic           go_tx;
    logic           tx_emit;
    logic           tx_bit;

    // rx_shift holds frame bits 2..46 once the end bit is on the line
    assign rx_crc_clr = (state == S_IDLE);
    assign rx_crc_en  = (state == S_RX) && (rx_cnt < CMD_CRC_SPAN);

    assign tx_data_len = tx_long ? LONG_CRC_END : SHORT_CRC_END;
    assign tx_len      = tx_long ? LONG_FRAME_LEN : SHORT_FRAME_LEN;
    assign go_tx       = (state == S_WAIT_RESP) && have_resp && (ncr_cnt >= 8'(NCR_MIN));
    assign tx_emit     = go_tx || ((state == S_TX) && (tx_cnt < tx_len));
    assign tx_crc_clr  = (state == S_WAIT_RESP) && !have_resp && resp_valid;
    assign tx_crc_en   = tx_emit && (tx_cnt < tx_data_len) && (!tx_long || (tx_cnt >= LONG_HDR_LEN));

    // Both payload lengths are multiples of 8, so the CRC bit position
    // within the 7-bit field follows directly from the low counter bits.
    assign tx_crc_sel = 3'd6 - tx_cnt[2:0];

    always_comb begin
        tx_bit = 1'b1;
        if (tx_cnt < tx_data_len) begin
            tx_bit = tx_shift[135];
        end else if (tx_cnt < tx_data_len + 8'd7) begin
            tx_bit = crc_tx[tx_crc_sel];
        end
    end

    assign busy = (state != S_IDLE);

    sd_crc7 u_crc_rx (
        .clk      (clk_SD),
        .reset    (reset_SD),
        .clear    (rx_crc_clr),
        .enable   (rx_crc_en),
        .data_bit (CMD_PIN_IN),
        .crc      (crc_rx)
    );

    sd_crc7 u_crc_tx (
        .clk      (clk_SD),
        .reset    (reset_SD),
        .clear    (tx_crc_clr),
        .enable   (tx_crc_en),
        .data_bit (tx_bit),
        .crc      (crc_tx)
    );

    // Main command/response FSM; pulses default low every cycle, and the pad
    // driver below the case statement is shared by the WAIT_RESP->TX edge and TX
    always_ff @(posedge clk_SD) begin
        if (reset_SD) begin
            state         <= S_IDLE;
            rx_cnt        <= 6'd0;
            rx_shift      <= '0;
            rx_dir        <= 1'b0;
            ncr_cnt       <= 8'd0;
            have_resp     <= 1'b0;
            tx_long       <= 1'b0;
            tx_shift      <= '0;
            tx_cnt        <= 8'd0;
            CMD_PIN_OUT   <= 1'b1;
            io_enable_cmd <= 1'b0;
            cmd_valid     <= 1'b0;
            cmd_index     <= 6'd0;
            cmd_argument  <= 32'd0;
            crc_error     <= 1'b0;
            resp_timeout  <= 1'b0;
        end else begin
            cmd_valid    <= 1'b0;
            crc_error    <= 1'b0;
            resp_timeout <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (!CMD_PIN_IN) begin
                        state  <= S_RX;
                        rx_cnt <= 6'd1;
                    end
                end

                S_RX: begin
                    rx_shift <= {rx_shift[43:0], CMD_PIN_IN};
                    rx_cnt   <= rx_cnt + 6'd1;
                    if (rx_cnt == 6'd1) begin
                        rx_dir <= CMD_PIN_IN;
                    end
                    // Card-to-host frames are swallowed whole and dropped silently
                    if (rx_cnt == CMD_LAST_BIT) begin
                        state <= S_IDLE;
                        if (rx_dir) begin
                            if ((crc_rx == rx_shift[6:0]) && CMD_PIN_IN) begin
                                cmd_index    <= rx_shift[44:39];
                                cmd_argument <= rx_shift[38:7];
                                cmd_valid    <= 1'b1;
                                state        <= S_WAIT_RESP;
                                ncr_cnt      <= 8'd1;
                                have_resp    <= 1'b0;
                            end else begin
                                crc_error <= 1'b1;
                            end
                        end
                    end
                end

                S_WAIT_RESP: begin
                    ncr_cnt <= ncr_cnt + 8'd1;
                    if (!have_resp) begin
                        if (resp_valid) begin
                            if ((resp_type == RESP_SHORT) || (resp_type == RESP_LONG)) begin
                                have_resp <= 1'b1;
                                tx_long   <= (resp_type == RESP_LONG);
                                tx_cnt    <= 8'd0;
                                tx_shift  <= (resp_type == RESP_LONG) ?
                                             {2'b00, 6'b111111, resp_long} :
                                             {2'b00, cmd_index, resp_status, 96'd0};
                            end else begin
                                state <= S_IDLE;
                            end
                        end else if (ncr_cnt == 8'(NCR_MAX)) begin
                            resp_timeout <= 1'b1;
                            state        <= S_IDLE;
                        end
                    end else if (go_tx) begin
                        state         <= S_TX;
                        io_enable_cmd <= 1'b1;
                    end
                end

                S_TX: begin
                    if (tx_cnt == tx_len) begin
                        io_enable_cmd <= 1'b0;
                        CMD_PIN_OUT   <= 1'b1;
                        state         <= S_IDLE;
                    end
                end

                default: state <= S_IDLE;
            endcase

            if (tx_emit) begin
                CMD_PIN_OUT <= tx_bit;
                tx_cnt      <= tx_cnt + 8'd1;
                if (tx_cnt < tx_data_len) begin
                    tx_shift <= {tx_shift[134:0], 1'b0};
                end
            end
        end
    end

endmodule

// File: tb/tb_sd_card_cmd_responder.sv
// Directed bench for the card-side CMD responder: drives host frames bit by
// bit on negedges and checks decode, response framing, CRC7, timeout and reset.
module tb_sd_card_cmd_responder;
    import sd_cmd_pkg::*;

    logic         clk_SD = 1'b0;
    logic         reset_SD;
    logic         CMD_PIN_IN;
    logic         CMD_PIN_OUT;
    logic         io_enable_cmd;
    logic         cmd_valid;
    logic [5:0]   cmd_index;
    logic [31:0]  cmd_argument;
    logic         crc_error;
    logic         resp_valid;
    logic [1:0]   resp_type;
    logic [31:0]  resp_status;
    logic [127:0] resp_long;
    logic         resp_timeout;
    logic         busy;

    int vectors = 0;
    int miscompares = 0;

    localparam logic [47:0]  CMD0_FRAME     = 48'h40_0000_0000_95;
    localparam logic [47:0]  CMD8_FRAME     = 48'h48_0000_01AA_87;
    localparam logic [47:0]  CMD8_BAD_FRAME = 48'h48_0000_01AB_87;
    localparam logic [127:0] LONG_PAYLOAD   = 128'h0123456789ABCDEF0123456789ABCDEF;

    always #5 clk_SD = ~clk_SD;

    sd_card_cmd_responder #(
        .NCR_MIN (2),
        .NCR_MAX (64)
    ) dut (
        .clk_SD        (clk_SD),
        .reset_SD      (reset_SD),
        .CMD_PIN_IN    (CMD_PIN_IN),
        .CMD_PIN_OUT   (CMD_PIN_OUT),
        .io_enable_cmd (io_enable_cmd),
        .cmd_valid     (cmd_valid),
        .cmd_index     (cmd_index),
        .cmd_argument  (cmd_argument),
        .crc_error     (crc_error),
        .resp_valid    (resp_valid),
        .resp_type     (resp_type),
        .resp_status   (resp_status),
        .resp_long     (resp_long),
        .resp_timeout  (resp_timeout),
        .busy          (busy)
    );

    task automatic checkOutput(input string tag, input logic [135:0] got, input logic [135:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference CRC7 over data[n-1:0], MSB first, initial value zero
    function automatic logic [6:0] crc7Model(input logic [127:0] data, input int n);
        logic [6:0] c;
        logic       fb;
        c = 7'h00;
        for (int i = n - 1; i >= 0; i--) begin
            fb = data[i] ^ c[6];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'b000_1001;
        end
        return c;
    endfunction

    function automatic logic [47:0] makeCmd(input logic [5:0] idx, input logic [31:0] arg);
        logic [39:0] head;
        head = {2'b01, idx, arg};
        return {head, crc7Model({88'd0, head}, 40), 1'b1};
    endfunction

    // Drives a 48-bit frame starting now; returns half a cycle after the end-bit edge E
    task automatic applyStimulus(input logic [47:0] frame);
        CMD_PIN_IN = frame[47];
        for (int i = 46; i >= 0; i--) begin
            @(negedge clk_SD);
            CMD_PIN_IN = frame[i];
        end
        @(negedge clk_SD);
        CMD_PIN_IN = 1'b1;
    endtask

    // Called at E+0.5; presents resp_valid so that it is sampled at edge E+delay
    task automatic respondAt(input int delay, input logic [1:0] rtype, input logic [31:0] status,
                             input logic [127:0] lng, output logic early);
        early = io_enable_cmd;
        for (int i = 1; i < delay; i++) begin
            @(negedge clk_SD);
            early = early | io_enable_cmd;
        end
        resp_valid  = 1'b1;
        resp_type   = rtype;
        resp_status = status;
        resp_long   = lng;
        @(negedge clk_SD);
        early = early | io_enable_cmd;
        resp_valid = 1'b0;
    endtask

    task automatic captureResp(output logic [135:0] got, output int waitCnt, output int enCnt);
        got     = '0;
        waitCnt = 0;
        enCnt   = 0;
        while (!io_enable_cmd && waitCnt < 100) begin
            @(negedge clk_SD);
            waitCnt++;
        end
        while (io_enable_cmd && enCnt < 200) begin
            got = {got[134:0], CMD_PIN_OUT};
            enCnt++;
            @(negedge clk_SD);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [135:0] got;
        logic [135:0] exp;
        logic [39:0]  shortHead;
        logic         early;
        logic         seen;
        int           waitCnt;
        int           enCnt;
        int           cnt;

        CMD_PIN_IN  = 1'b1;
        reset_SD    = 1'b1;
        resp_valid  = 1'b0;
        resp_type   = RESP_NONE;
        resp_status = 32'd0;
        resp_long   = 128'd0;
        repeat (3) @(negedge clk_SD);

        checkOutput("rst_pin_out",   136'(CMD_PIN_OUT),   136'(1));
        checkOutput("rst_io_enable", 136'(io_enable_cmd), 136'(0));
        checkOutput("rst_cmd_valid", 136'(cmd_valid),     136'(0));
        checkOutput("rst_index",     136'(cmd_index),     136'(0));
        checkOutput("rst_argument",  136'(cmd_argument),  136'(0));
        checkOutput("rst_crc_error", 136'(crc_error),     136'(0));
        checkOutput("rst_timeout",   136'(resp_timeout),  136'(0));
        checkOutput("rst_busy",      136'(busy),          136'(0));
        reset_SD = 1'b0;
        @(negedge clk_SD);

        // CMD0, card declines to respond
        applyStimulus(CMD0_FRAME);
        checkOutput("cmd0_valid",    136'(cmd_valid),    136'(1));
        checkOutput("cmd0_index",    136'(cmd_index),    136'(0));
        checkOutput("cmd0_argument", 136'(cmd_argument), 136'(0));
        checkOutput("cmd0_busy",     136'(busy),         136'(1));
        resp_valid = 1'b1;
        resp_type  = RESP_NONE;
        @(negedge clk_SD);
        resp_valid = 1'b0;
        checkOutput("cmd0_pulse_end", 136'(cmd_valid), 136'(0));
        checkOutput("cmd0_idle",      136'(busy),      136'(0));
        seen = io_enable_cmd;
        repeat (8) begin
            @(negedge clk_SD);
            seen = seen | io_enable_cmd;
        end
        checkOutput("cmd0_no_drive", 136'(seen), 136'(0));

        // CMD8 with short R7 echo, resp_valid at E+1
        applyStimulus(CMD8_FRAME);
        checkOutput("cmd8_valid",    136'(cmd_valid),    136'(1));
        checkOutput("cmd8_index",    136'(cmd_index),    136'(8));
        checkOutput("cmd8_argument", 136'(cmd_argument), 136'(32'h1AA));
        respondAt(1, RESP_SHORT, 32'h0000_01AA, 128'd0, early);
        checkOutput("cmd8_no_early", 136'(early), 136'(0));
        captureResp(got, waitCnt, enCnt);
        shortHead = {2'b00, 6'd8, 32'h0000_01AA};
        exp = {88'd0, shortHead, crc7Model({88'd0, shortHead}, 40), 1'b1};
        checkOutput("cmd8_start_delay", 136'(waitCnt), 136'(1));
        checkOutput("cmd8_enable_len",  136'(enCnt),   136'(48));
        checkOutput("cmd8_resp_frame",  got,           exp);
        checkOutput("cmd8_pin_release", 136'(CMD_PIN_OUT), 136'(1));
        checkOutput("cmd8_tx_idle",     136'(busy),        136'(0));

        // CMD8 with a flipped argument bit
        applyStimulus(CMD8_BAD_FRAME);
        checkOutput("bad_crc_error", 136'(crc_error),    136'(1));
        checkOutput("bad_no_valid",  136'(cmd_valid),    136'(0));
        checkOutput("bad_idle",      136'(busy),         136'(0));
        checkOutput("bad_arg_held",  136'(cmd_argument), 136'(32'h1AA));
        @(negedge clk_SD);
        checkOutput("bad_pulse_end", 136'(crc_error), 136'(0));

        // CMD2 with long R2, resp_valid at E+10
        applyStimulus(makeCmd(6'd2, 32'd0));
        checkOutput("cmd2_valid", 136'(cmd_valid), 136'(1));
        checkOutput("cmd2_index", 136'(cmd_index), 136'(2));
        respondAt(10, RESP_LONG, 32'd0, LONG_PAYLOAD, early);
        checkOutput("cmd2_no_early", 136'(early), 136'(0));
        captureResp(got, waitCnt, enCnt);
        exp = {2'b00, 6'b111111, LONG_PAYLOAD[127:8],
               crc7Model({8'd0, LONG_PAYLOAD[127:8]}, 120), 1'b1};
        checkOutput("cmd2_start_delay", 136'(waitCnt), 136'(1));
        checkOutput("cmd2_enable_len",  136'(enCnt),   136'(136));
        checkOutput("cmd2_resp_frame",  got,           exp);

        // CMD55 starts right after TX exit and is never answered
        applyStimulus(makeCmd(6'd55, 32'd0));
        checkOutput("cmd55_valid", 136'(cmd_valid), 136'(1));
        checkOutput("cmd55_index", 136'(cmd_index), 136'(55));
        cnt = 0;
        while (!resp_timeout && cnt < 100) begin
            @(negedge clk_SD);
            cnt++;
        end
        checkOutput("timeout_cycles", 136'(cnt),  136'(64));
        checkOutput("timeout_idle",   136'(busy), 136'(0));
        @(negedge clk_SD);
        checkOutput("timeout_pulse_end", 136'(resp_timeout), 136'(0));

        applyStimulus(CMD8_FRAME);
        checkOutput("post_timeout_valid", 136'(cmd_valid), 136'(1));
        resp_valid = 1'b1;
        resp_type  = RESP_NONE;
        @(negedge clk_SD);
        resp_valid = 1'b0;

        // Reset while bit 20 of a long response is on the pad
        applyStimulus(makeCmd(6'd2, 32'd0));
        respondAt(1, RESP_LONG, 32'd0, LONG_PAYLOAD, early);
        cnt = 0;
        while (!io_enable_cmd && cnt < 100) begin
            @(negedge clk_SD);
            cnt++;
        end
        repeat (20) @(negedge clk_SD);
        checkOutput("mid_tx_enabled", 136'(io_enable_cmd), 136'(1));
        reset_SD = 1'b1;
        @(negedge clk_SD);
        checkOutput("rst_tx_enable", 136'(io_enable_cmd), 136'(0));
        checkOutput("rst_tx_pin",    136'(CMD_PIN_OUT),   136'(1));
        checkOutput("rst_tx_busy",   136'(busy),          136'(0));
        checkOutput("rst_tx_index",  136'(cmd_index),     136'(0));
        reset_SD = 1'b0;
        @(negedge clk_SD);

        applyStimulus(CMD0_FRAME);
        checkOutput("post_rst_valid",     136'(cmd_valid),    136'(1));
        checkOutput("post_rst_index",     136'(cmd_index),    136'(0));
        checkOutput("post_rst_argument",  136'(cmd_argument), 136'(0));
        checkOutput("post_rst_crc_error", 136'(crc_error),    136'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
